// File: rtl/z_writeback.sv
// Result write-back stage downstream of the ALU.
// Captures the 64-bit ALU result into Z on Zin and derives the zero/negative flags.
// It then drives Z onto the 32-bit bus in one beat (narrow op) or two beats
// (MUL/DIV: LO then HI), each beat under a bus request/grant handshake.
//
// Ports:
//   clk          sole clock, rising edge
//   clr          synchronous active-low reset
//   ctrl_signal  one-hot ALU control vector (same one the ALU sees)
//   OpResult     ALU result {hi, lo}
//   Zin          capture strobe
//   bus_gnt      arbiter grant
//   bus_req      request to drive the bus
//   bus_out      bus data; zero whenever bus_req is low
//   lo_wr/hi_wr  write strobes for the register/LO and for HI, asserted on grant cycles
//   z_lo/z_hi    Z register contents
//   busy         transfer in progress
//   done         one-cycle pulse in the first idle cycle after the final beat
//   zero_flag    result-is-zero flag
//   neg_flag     result-is-negative flag
//   err_overrun  sticky; set when Zin arrives while busy, cleared only by reset
module z_writeback #(
  parameter int unsigned BITS      = 32,
  parameter int unsigned SIG_COUNT = 12,
  parameter int unsigned MUL_BIT   = 2,
  parameter int unsigned DIV_BIT   = 3
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [SIG_COUNT-1:0] ctrl_signal,
  input  logic [2*BITS-1:0]    OpResult,
  input  logic                 Zin,
  input  logic                 bus_gnt,
  output logic                 bus_req,
  output logic [BITS-1:0]      bus_out,
  output logic                 lo_wr,
  output logic                 hi_wr,
  output logic [BITS-1:0]      z_lo,
  output logic [BITS-1:0]      z_hi,
  output logic                 busy,
  output logic                 done,
  output logic                 zero_flag,
  output logic                 neg_flag,
  output logic                 err_overrun
);

  typedef enum logic [1:0] {StIdle, StSendLo, StSendHi} state_e;

  state_e          state_q;
  logic [BITS-1:0] z_lo_q, z_hi_q;
  logic            wide_q;
  logic            done_q;
  logic            zero_q, neg_q;
  logic            err_q;

  logic            is_mul;
  logic            is_wide;

  assign is_mul  = ctrl_signal[MUL_BIT];
  assign is_wide = ctrl_signal[MUL_BIT] | ctrl_signal[DIV_BIT];

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q <= StIdle;
      z_lo_q  <= '0;
      z_hi_q  <= '0;
      wide_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (Zin) begin
            z_lo_q  <= OpResult[BITS-1:0];
            z_hi_q  <= OpResult[2*BITS-1:BITS];
            wide_q  <= is_wide;
            // Only MUL produces a true 64-bit value; DIV's hi half is the remainder.
            zero_q  <= is_mul ? (OpResult == '0) : (OpResult[BITS-1:0] == '0);
            neg_q   <= is_mul ? OpResult[2*BITS-1] : OpResult[BITS-1];
            state_q <= StSendLo;
          end
        end
        StSendLo: begin
          if (Zin) err_q <= 1'b1;
          if (bus_gnt) begin
            if (wide_q) begin
              state_q <= StSendHi;
            end else begin
              state_q <= StIdle;
              done_q  <= 1'b1;
            end
          end
        end
        StSendHi: begin
          if (Zin) err_q <= 1'b1;
          if (bus_gnt) begin
            state_q <= StIdle;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    busy    = 1'b0;
    bus_out = '0;
    lo_wr   = 1'b0;
    hi_wr   = 1'b0;
    unique case (state_q)
      StSendLo: begin
        busy    = 1'b1;
        bus_out = z_lo_q;
        lo_wr   = bus_gnt;
      end
      StSendHi: begin
        busy    = 1'b1;
        bus_out = z_hi_q;
        hi_wr   = bus_gnt;
      end
      default: ;
    endcase
  end

  assign bus_req     = busy;
  assign z_lo        = z_lo_q;
  assign z_hi        = z_hi_q;
  assign done        = done_q;
  assign zero_flag   = zero_q;
  assign neg_flag    = neg_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_z_writeback.sv
module tb_z_writeback;

  logic        clk;
  logic        clr;
  logic [11:0] ctrl_signal;
  logic [63:0] OpResult;
  logic        Zin;
  logic        bus_gnt;
  logic        bus_req;
  logic [31:0] bus_out;
  logic        lo_wr;
  logic        hi_wr;
  logic [31:0] z_lo;
  logic [31:0] z_hi;
  logic        busy;
  logic        done;
  logic        zero_flag;
  logic        neg_flag;
  logic        err_overrun;

  z_writeback #(
    .BITS      (32),
    .SIG_COUNT (12),
    .MUL_BIT   (2),
    .DIV_BIT   (3)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .ctrl_signal (ctrl_signal),
    .OpResult    (OpResult),
    .Zin         (Zin),
    .bus_gnt     (bus_gnt),
    .bus_req     (bus_req),
    .bus_out     (bus_out),
    .lo_wr       (lo_wr),
    .hi_wr       (hi_wr),
    .z_lo        (z_lo),
    .z_hi        (z_hi),
    .busy        (busy),
    .done        (done),
    .zero_flag   (zero_flag),
    .neg_flag    (neg_flag),
    .err_overrun (err_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference model: a queue of beats still owed to the bus.
  typedef struct packed {
    logic [31:0] data;
    logic        hi;
  } beat_t;

  beat_t       beats[$];
  logic [31:0] m_zlo, m_zhi;
  logic        m_zero, m_neg, m_err, m_done;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outputs();
    logic        e_req;
    logic [31:0] e_out;
    e_req = (beats.size() != 0);
    e_out = e_req ? beats[0].data : 32'h0;
    check("bus_req", 64'(bus_req), 64'(e_req));
    check("busy", 64'(busy), 64'(e_req));
    check("bus_out", 64'(bus_out), 64'(e_out));
    check("lo_wr", 64'(lo_wr), 64'(e_req && bus_gnt && !beats[0].hi));
    check("hi_wr", 64'(hi_wr), 64'(e_req && bus_gnt && beats[0].hi));
    check("done", 64'(done), 64'(m_done));
    check("z_lo", 64'(z_lo), 64'(m_zlo));
    check("z_hi", 64'(z_hi), 64'(m_zhi));
    check("zero_flag", 64'(zero_flag), 64'(m_zero));
    check("neg_flag", 64'(neg_flag), 64'(m_neg));
    check("err_overrun", 64'(err_overrun), 64'(m_err));
  endtask

  task automatic model_edge();
    logic idle, last, mul, wide;
    beat_t b;
    if (!clr) begin
      beats.delete();
      m_zlo = 0; m_zhi = 0; m_zero = 0; m_neg = 0; m_err = 0; m_done = 0;
    end else begin
      idle = (beats.size() == 0);
      last = 1'b0;
      if (!idle && bus_gnt) begin
        last = (beats.size() == 1);
        void'(beats.pop_front());
      end
      m_done = last;
      if (Zin) begin
        if (idle) begin
          mul    = ctrl_signal[2];
          wide   = ctrl_signal[2] | ctrl_signal[3];
          m_zlo  = OpResult[31:0];
          m_zhi  = OpResult[63:32];
          m_zero = mul ? (OpResult == 64'h0) : (OpResult[31:0] == 32'h0);
          m_neg  = mul ? OpResult[63] : OpResult[31];
          b.data = OpResult[31:0];
          b.hi   = 1'b0;
          beats.push_back(b);
          if (wide) begin
            b.data = OpResult[63:32];
            b.hi   = 1'b1;
            beats.push_back(b);
          end
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: drive inputs, check mid-cycle, advance the model with the edge.
  task automatic step(input logic c, input logic z, input logic g,
                      input logic [11:0] cs, input logic [63:0] op);
    clr = c; Zin = z; bus_gnt = g; ctrl_signal = cs; OpResult = op;
    @(negedge clk);
    check_outputs();
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_cycles(input int n, input logic g);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, g, 12'h000, 64'h0);
  endtask

  initial begin
    logic [11:0] cs;
    logic [63:0] op;
    clr = 1'b0; Zin = 1'b0; bus_gnt = 1'b0; ctrl_signal = '0; OpResult = '0;
    beats.delete();
    m_zlo = 0; m_zhi = 0; m_zero = 0; m_neg = 0; m_err = 0; m_done = 0;
    @(posedge clk);
    #1;
    step(1'b0, 1'b0, 1'b0, 12'h000, 64'h0);
    step(1'b0, 1'b1, 1'b1, 12'h004, 64'hFFFF_FFFF_FFFF_FFFF);

    // ADD, narrow, grant held
    step(1'b1, 1'b1, 1'b1, 12'h001, 64'h0000_0000_0000_0008);
    idle_cycles(3, 1'b1);

    // MUL -15*5
    step(1'b1, 1'b1, 1'b1, 12'h004, 64'hFFFF_FFFF_FFFF_FFB5);
    idle_cycles(4, 1'b1);

    // DIV -15/5, grant withheld for three cycles
    step(1'b1, 1'b1, 1'b0, 12'h008, 64'h0000_0000_FFFF_FFFD);
    idle_cycles(3, 1'b0);
    idle_cycles(4, 1'b1);

    // Overrun: second Zin while waiting for grant
    step(1'b1, 1'b1, 1'b0, 12'h001, 64'h0000_0000_1234_5678);
    step(1'b1, 1'b1, 1'b0, 12'h001, 64'hDEAD_BEEF_8765_4321);
    idle_cycles(1, 1'b0);
    idle_cycles(3, 1'b1);

    // Reset while a MUL sits in its HI beat
    step(1'b1, 1'b1, 1'b1, 12'h004, 64'h0000_0007_0000_0003);
    step(1'b1, 1'b0, 1'b1, 12'h000, 64'h0);
    step(1'b0, 1'b0, 1'b0, 12'h000, 64'h0);
    idle_cycles(3, 1'b1);

    // Zero MUL, then a new Zin landing on the done cycle
    step(1'b1, 1'b1, 1'b1, 12'b000000000100, 64'h0);
    idle_cycles(2, 1'b1);
    step(1'b1, 1'b1, 1'b1, 12'h001, 64'h0000_0000_8000_0000);
    idle_cycles(3, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       cs = 12'h004;
        1:       cs = 12'h008;
        2:       cs = 12'(1 << $urandom_range(0, 11));
        default: cs = 12'($urandom);
      endcase
      op = {32'($urandom), 32'($urandom)};
      if ($urandom_range(0, 7) == 0) op = 64'h0;
      if ($urandom_range(0, 7) == 0) op[63:32] = 32'h0;
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0), cs, op);
    end
    idle_cycles(4, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/z_writeback.md
# z_writeback

Result write-back stage sitting directly downstream of the ALU in the Phase 1 bus datapath. Captures the ALU's 64-bit `OpResult` into the Z register on `Zin`, derives zero/negative flags, and then drives the result onto the 32-bit bus. Narrow ops use one beat (Z low). MUL/DIV use two beats (Z low to LO, then Z high to HI), each under a request/grant handshake with the bus arbiter.

## Interface
- `BITS`, 32, datapath word width
- `SIG_COUNT`, 12, width of the one-hot ALU control vector
- `MUL_BIT`, 2, index of the multiply bit in `ctrl_signal`
- `DIV_BIT`, 3, index of the divide bit in `ctrl_signal`

Ports:
- `clk`  in  1  sole clock, rising edge
- `clr`  in  1  reset; synchronous, active-low: sampled low on a rising edge resets the block
- `ctrl_signal`  in  SIG_COUNT  same one-hot control vector that feeds the ALU
- `OpResult`  in  2*BITS  ALU result; `{hi, lo}`; for DIV, lo = quotient and hi = remainder
- `Zin`  in  1  capture strobe
- `bus_gnt`  in  1  arbiter grant
- `bus_req`  out  1  request to drive the bus
- `bus_out`  out  BITS  bus data
- `lo_wr`  out  1  write strobe for the general register (narrow op) or LO (wide op)
- `hi_wr`  out  1  write strobe for HI
- `z_lo`, `z_hi`  out  BITS  Z register contents
- `busy`  out  1  transfer in progress
- `done`  out  1  one-cycle completion pulse
- `zero_flag`, `neg_flag`  out  1  result flags
- `err_overrun`  out  1  sticky: `Zin` arrived while busy

## Operation
- States:
  - IDLE
  - SEND_LO
  - SEND_HI
- IDLE:
  - `busy=0`.
  - When `Zin=1`, register on the edge:
    - `z_hi`/`z_lo` ← `OpResult`
    - `wide` ← `ctrl_signal[MUL_BIT] | ctrl_signal[DIV_BIT]`
    - flags as below
  - Then go to SEND_LO.
  - `ctrl_signal` all-zero or multi-hot is still captured; `wide` follows the OR above.
- Flags:
  - MUL: `zero_flag = ({z_hi,z_lo}==0)`, `neg_flag = z_hi[BITS-1]`.
  - All other ops, including DIV: `zero_flag = (z_lo==0)`, `neg_flag = z_lo[BITS-1]`.
  - Flags hold until the next capture.
- SEND_LO:
  - `bus_req=1`, `bus_out=z_lo`.
  - A beat completes in any cycle with `bus_req & bus_gnt`; that same cycle `lo_wr=1` (combinational, one cycle only).
  - On completion: `wide` → SEND_HI, else → IDLE.
  - Without grant, stay in SEND_LO indefinitely with `bus_out` stable.
- SEND_HI:
  - `bus_req=1`, `bus_out=z_hi`.
  - The grant cycle asserts `hi_wr=1`, then → IDLE.
- `done`:
  - Registered.
  - High for exactly the one cycle after the final beat, i.e. the first IDLE cycle.
- `Zin` while `busy=1`:
  - Ignored; Z and flags are not modified.
  - `err_overrun` ← 1; it clears only on reset.
- `Zin` in the same cycle `done=1`: accepted normally (state is IDLE).
- `bus_out` is 0 whenever `bus_req=0`.
- `lo_wr`/`hi_wr` are never asserted without `bus_gnt`.

## Timing
- Reset (edge with `clr=0`):
  - State → IDLE.
  - `z_lo`, `z_hi`, `zero_flag`, `neg_flag`, `err_overrun`, `done` → 0.
  - `bus_req`, `bus_out`, `lo_wr`, `hi_wr`, `busy` are 0 from the following cycle.
- Reset mid-transfer:
  - Abandons the transfer.
  - No further `lo_wr`/`hi_wr`, no `done`.
- `Zin` sampled at edge N with `bus_gnt` held high:
  - Narrow: LO beat in cycle N+1, `done` in N+2.
  - Wide: LO beat in N+1, HI beat in N+2, `done` in N+3.
- Each cycle without grant adds one cycle of latency to the pending beat.
- `busy=1` exactly while in SEND_LO or SEND_HI.

## Test plan
- ADD (bit 0), `OpResult=0x0000_0000_0000_0008`, `Zin` 1 cycle, `bus_gnt=1`:
  - Cycle N+1: `bus_out=8`, `lo_wr=1`.
  - No `hi_wr`.
  - `done` at N+2.
  - `zero_flag=0`, `neg_flag=0`.
- MUL (bit 2), `OpResult=0xFFFF_FFFF_FFFF_FFB5` (-15*5), `bus_gnt=1`:
  - LO beat `0xFFFFFFB5` with `lo_wr`.
  - HI beat `0xFFFFFFFF` with `hi_wr`.
  - `done` at N+3.
  - `neg_flag=1`, `zero_flag=0`.
- DIV (bit 3), `OpResult=0x0000_0000_FFFF_FFFD` (-15/5), `bus_gnt` low for 3 cycles then high:
  - `bus_req` holds 3 cycles with `bus_out=0xFFFFFFFD`.
  - Then LO beat, then HI beat = 0.
  - `neg_flag=1`.
  - `done` 6 cycles after capture.
- Overrun:
  - Second `Zin` with different `OpResult` during SEND_LO (no grant) → `err_overrun=1`; `z_lo`/`z_hi` unchanged.
  - First transfer completes with the original data.
- Reset mid-op: `clr=0` during SEND_HI of a MUL →
  - Next cycle all outputs 0, state IDLE.
  - No `hi_wr`, no `done`.
  - `err_overrun` cleared.
- Zero MUL result `0` with `ctrl_signal=12'b000000000100` → `zero_flag=1`. Back-to-back `Zin` coinciding with `done` → accepted; second transfer starts the next cycle.
